stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Control unit driving the core's one-hot six-stage instruction cycle: FETCH, DECODE, READ, EXECUTE, MEMORY, WRITE_BACK.
- Skips optional stages (READ, MEMORY) from the per-instruction enable mask latched in DECODE.
- Holds FETCH and MEMORY on bus req/ack handshakes, with a watchdog timeout.
- Supports trap abort and counts retired instructions.

Parameters:
- WAIT_TIMEOUT, 255: max cycles req stays high in FETCH/MEMORY before abort; 0 disables the watchdog.
- RETIRE_W, 32: width of retired-instruction counter.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: reset; one clock; reset is asynchronous and active-low.
- stage_enabled, input, 6: decoder enable mask, bit index = stage (FETCH=0 .. WRITE_BACK=5); sampled only in DECODE.
- fetch_ack, input, 1: instruction bus completes fetch.
- mem_ack, input, 1: data bus completes access.
- trap, input, 1: abort current instruction.
- stage_active, output, 6: one-hot current stage.
- fetch_req, output, 1: instruction bus request.
- mem_req, output, 1: data bus request.
- instr_retired, output, 1: one-cycle retire pulse.
- trap_taken, output, 1: one-cycle abort pulse, trap cause.
- bus_timeout, output, 1: one-cycle abort pulse, watchdog cause.
- retire_count, output, RETIRE_W: retired-instruction count.

Behaviour:
- Reset (async assert): stage_active=6'b100000 (WRITE_BACK); en_q=0; wait_cnt=0; retire_count=0; instr_retired, trap_taken, bus_timeout all 0.
  - First rising edge after release goes to FETCH; no retire for this pseudo-WRITE_BACK.
- fetch_req = stage_active[0]; mem_req = stage_active[4]. Both combinational from state, no extra latency.
- Transitions, evaluated at posedge when trap=0:
  - FETCH: stay until fetch_ack=1, then DECODE.
  - DECODE: 1 cycle. Latch en_q <= stage_enabled | 6'b101011 (bits 0,1,3,5 forced). Next is READ if stage_enabled[2], else EXECUTE; use the live input, not en_q.
  - READ: 1 cycle, then EXECUTE.
  - EXECUTE: 1 cycle, then MEMORY if en_q[4], else WRITE_BACK.
  - MEMORY: stay until mem_ack=1, then WRITE_BACK.
  - WRITE_BACK: 1 cycle, then FETCH. Registered instr_retired=1 in the following (first FETCH) cycle; retire_count+1, wrapping at 2^RETIRE_W.
- fetch_ack/mem_ack are ignored outside their stage.
- Trap: trap=1 in any stage other than WRITE_BACK → next stage FETCH, no retire, trap_taken=1 for one cycle (coincident with FETCH entry).
  - trap in WRITE_BACK is ignored; the instruction retires.
  - trap beats a same-cycle ack.
- Watchdog:
  - wait_cnt clears on entry to FETCH/MEMORY and increments each cycle in FETCH/MEMORY without ack.
  - If WAIT_TIMEOUT≠0 and wait_cnt==WAIT_TIMEOUT-1 with no ack → next FETCH, bus_timeout=1 one cycle, no retire. Req is therefore high exactly WAIT_TIMEOUT cycles.
  - Same-cycle ack beats timeout; trap beats both, and only trap_taken pulses.
  - Counter saturates, never wraps.
- Reset mid-operation: immediate return to reset values; in-flight req drops asynchronously; no pulses.
- Invariant: stage_active is always exactly one-hot. Illegal state (unreachable) recovers to FETCH next cycle.

Test Plan:
- Release reset, fetch_ack tied 1, stage_enabled=6'b111111 → stage_active sequence 100000,000001,000010,000100,001000,010000,100000 (mem_ack=1); instr_retired at next 000001; retire_count=1.
- stage_enabled=6'b000000, acks tied 1 → DECODE→EXECUTE→WRITE_BACK, 4 cycles/instruction; 10 instructions give retire_count=10.
- fetch_ack held 0 for 3 cycles, then 1 → FETCH held 4 cycles, fetch_req high all 4, DECODE next.
- WAIT_TIMEOUT=4, mem_ack never → mem_req high exactly 4 cycles, then FETCH, bus_timeout one pulse, retire_count unchanged. Repeat with mem_ack on 4th cycle → WRITE_BACK, no bus_timeout.
- trap=1 in READ → next FETCH, trap_taken pulse, no retire. trap=1 in WRITE_BACK → normal retire. trap and fetch_ack same cycle → FETCH again, trap_taken.
- Assert reset_n=0 mid-MEMORY, between clock edges → stage_active=100000 and mem_req=0 immediately, retire_count=0.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: one-hot six-stage instruction-cycle controller.
// It skips the optional READ and MEMORY stages, waits on the bus handshakes,
// and aborts an instruction on a trap or a bus watchdog timeout.
// It also counts retired instructions.
module stage_sequencer #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned RETIRE_W     = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          stage_enabled,
  input  logic                fetch_ack,
  input  logic                mem_ack,
  input  logic                trap,
  output logic [5:0]          stage_active,
  output logic                fetch_req,
  output logic                mem_req,
  output logic                instr_retired,
  output logic                trap_taken,
  output logic                bus_timeout,
  output logic [RETIRE_W-1:0] retire_count
);

  typedef enum logic [5:0] {
    S_FETCH   = 6'b000001,
    S_DECODE  = 6'b000010,
    S_READ    = 6'b000100,
    S_EXECUTE = 6'b001000,
    S_MEMORY  = 6'b010000,
    S_WB      = 6'b100000
  } stage_e;

  localparam int unsigned CNT_W = (WAIT_TIMEOUT == 0) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [5:0]       EN_FORCE = 6'b101011;

  stage_e               state_q, state_d;
  logic [5:0]           en_q, en_d;
  logic [CNT_W-1:0]     wait_q, wait_d, wait_inc;
  logic                 armed_q;
  logic                 retire_d, trap_d, tmo_d, tmo_hit;
  logic                 retired_q, trap_q, tmo_q;
  logic [RETIRE_W-1:0]  retire_cnt_q;

  // Only the MEMORY enable steers sequencing; the other bits are forced or read live.
  logic unused_en;
  assign unused_en = ^{en_q[5], en_q[3:0]};

  assign wait_inc = (wait_q == CNT_MAX) ? wait_q : wait_q + 1'b1;
  assign tmo_hit  = (WAIT_TIMEOUT != 0) && (wait_q == CNT_LAST);

  // Next-stage selection, watchdog counting and abort/retire pulse requests.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    wait_d   = '0;
    retire_d = 1'b0;
    trap_d   = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fetch_ack) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_FETCH;
          tmo_d   = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        en_d    = stage_enabled | EN_FORCE;
        state_d = stage_enabled[2] ? S_READ : S_EXECUTE;
      end
      S_READ:    state_d = S_EXECUTE;
      S_EXECUTE: state_d = en_q[4] ? S_MEMORY : S_WB;
      S_MEMORY: begin
        if (mem_ack) begin
          state_d = S_WB;
        end else if (tmo_hit) begin
          state_d = S_FETCH;
          tmo_d   = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_d = armed_q;
      end
      default: state_d = S_FETCH;
    endcase
    // A trap overrides any ack or timeout, except in WRITE_BACK where the instruction retires.
    if (trap && (state_q inside {S_FETCH, S_DECODE, S_READ, S_EXECUTE, S_MEMORY})) begin
      state_d = S_FETCH;
      trap_d  = 1'b1;
      tmo_d   = 1'b0;
      wait_d  = '0;
    end
  end

  // State register; reset parks in WRITE_BACK so the first edge enters FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WB;
    end else begin
      state_q <= state_d;
    end
  end

  // Enable mask, watchdog, pulse outputs and retire counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q         <= '0;
      wait_q       <= '0;
      armed_q      <= 1'b0;
      retired_q    <= 1'b0;
      trap_q       <= 1'b0;
      tmo_q        <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      en_q      <= en_d;
      wait_q    <= wait_d;
      armed_q   <= 1'b1;
      retired_q <= retire_d;
      trap_q    <= trap_d;
      tmo_q     <= tmo_d;
      if (retire_d) begin
        retire_cnt_q <= retire_cnt_q + 1'b1;
      end
    end
  end

  assign stage_active  = state_q;
  assign fetch_req     = state_q[0];
  assign mem_req       = state_q[4];
  assign instr_retired = retired_q;
  assign trap_taken    = trap_q;
  assign bus_timeout   = tmo_q;
  assign retire_count  = retire_cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer.
// The driver queues the expected per-cycle outputs alongside the stimulus.
// A negedge monitor pops and compares them.
module tb_stage_sequencer;

  localparam logic [5:0] F  = 6'b000001;
  localparam logic [5:0] D  = 6'b000010;
  localparam logic [5:0] R  = 6'b000100;
  localparam logic [5:0] E  = 6'b001000;
  localparam logic [5:0] M  = 6'b010000;
  localparam logic [5:0] WB = 6'b100000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  stage_enabled;
  logic        fetch_ack, mem_ack, trap;
  logic [5:0]  stage_active;
  logic        fetch_req, mem_req, instr_retired, trap_taken, bus_timeout;
  logic [31:0] retire_count;

  typedef struct {
    string       tag;
    logic [5:0]  stg;
    logic        ret;
    logic        trp;
    logic        tmo;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cnt  = 0;

  stage_sequencer #(.WAIT_TIMEOUT(4), .RETIRE_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stage_enabled (stage_enabled),
    .fetch_ack     (fetch_ack),
    .mem_ack       (mem_ack),
    .trap          (trap),
    .stage_active  (stage_active),
    .fetch_req     (fetch_req),
    .mem_req       (mem_req),
    .instr_retired (instr_retired),
    .trap_taken    (trap_taken),
    .bus_timeout   (bus_timeout),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue expectations for the current cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [5:0] stg, input logic ret,
                     input logic trp, input logic tmo);
    exp_t e;
    e.tag = tag; e.stg = stg; e.ret = ret; e.trp = trp; e.tmo = tmo; e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check_eq({mon_e.tag, ".stage"}, 64'(stage_active),  64'(mon_e.stg));
      check_eq({mon_e.tag, ".freq"},  64'(fetch_req),     64'(mon_e.stg[0]));
      check_eq({mon_e.tag, ".mreq"},  64'(mem_req),       64'(mon_e.stg[4]));
      check_eq({mon_e.tag, ".ret"},   64'(instr_retired), 64'(mon_e.ret));
      check_eq({mon_e.tag, ".trap"},  64'(trap_taken),    64'(mon_e.trp));
      check_eq({mon_e.tag, ".tmo"},   64'(bus_timeout),   64'(mon_e.tmo));
      check_eq({mon_e.tag, ".cnt"},   64'(retire_count),  64'(mon_e.cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; stage_enabled = '0; fetch_ack = 1'b0; mem_ack = 1'b0; trap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst", WB, 0, 0, 0);

    // Full instruction with every stage enabled.
    reset_n = 1'b1; stage_enabled = 6'b111111; fetch_ack = 1'b1; mem_ack = 1'b1;
    cyc("rel", WB, 0, 0, 0);
    cyc("t1f", F, 0, 0, 0);
    cyc("t1d", D, 0, 0, 0);
    cyc("t1r", R, 0, 0, 0);
    cyc("t1e", E, 0, 0, 0);
    cyc("t1m", M, 0, 0, 0);
    cyc("t1w", WB, 0, 0, 0);
    exp_cnt = 1;
    stage_enabled = 6'b000000;
    cyc("t1ret", F, 1, 0, 0);

    // Minimal instructions: DECODE, EXECUTE, WRITE_BACK, FETCH.
    for (int i = 0; i < 10; i++) begin
      cyc("t2d", D, 0, 0, 0);
      cyc("t2e", E, 0, 0, 0);
      cyc("t2w", WB, 0, 0, 0);
      exp_cnt++;
      cyc("t2f", F, 1, 0, 0);
    end

    // Fetch stall of 3 cycles; ack on the 4th cycle beats the timeout.
    cyc("t3d", D, 0, 0, 0);
    cyc("t3e", E, 0, 0, 0);
    fetch_ack = 1'b0;
    cyc("t3w", WB, 0, 0, 0);
    exp_cnt++;
    cyc("t3f0", F, 1, 0, 0);
    cyc("t3f1", F, 0, 0, 0);
    cyc("t3f2", F, 0, 0, 0);
    fetch_ack = 1'b1;
    cyc("t3f3", F, 0, 0, 0);

    // MEMORY watchdog: no ack for 4 cycles aborts without retiring.
    stage_enabled = 6'b010000; mem_ack = 1'b0;
    cyc("t4d", D, 0, 0, 0);
    cyc("t4e", E, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("t4m", M, 0, 0, 0);
    cyc("t4to", F, 0, 0, 1);
    cyc("t5d", D, 0, 0, 0);
    cyc("t5e", E, 0, 0, 0);
    cyc("t5m0", M, 0, 0, 0);
    cyc("t5m1", M, 0, 0, 0);
    cyc("t5m2", M, 0, 0, 0);
    mem_ack = 1'b1;
    cyc("t5m3", M, 0, 0, 0);
    mem_ack = 1'b0;
    cyc("t5w", WB, 0, 0, 0);
    exp_cnt++;
    cyc("t5f", F, 1, 0, 0);

    // Trap in READ aborts; trap in WRITE_BACK is ignored; trap beats fetch_ack.
    stage_enabled = 6'b000100;
    cyc("t6d", D, 0, 0, 0);
    trap = 1'b1;
    cyc("t6r", R, 0, 0, 0);
    trap = 1'b0;
    cyc("t6f", F, 0, 1, 0);
    cyc("t7d", D, 0, 0, 0);
    cyc("t7r", R, 0, 0, 0);
    cyc("t7e", E, 0, 0, 0);
    trap = 1'b1;
    cyc("t7w", WB, 0, 0, 0);
    exp_cnt++;
    cyc("t7f", F, 1, 0, 0);
    trap = 1'b0;
    cyc("t7ft", F, 0, 1, 0);

    // FETCH watchdog, then trap beating a same-cycle timeout.
    cyc("t8d", D, 0, 0, 0);
    cyc("t8r", R, 0, 0, 0);
    cyc("t8e", E, 0, 0, 0);
    fetch_ack = 1'b0;
    cyc("t8w", WB, 0, 0, 0);
    exp_cnt++;
    cyc("t8f0", F, 1, 0, 0);
    cyc("t8f1", F, 0, 0, 0);
    cyc("t8f2", F, 0, 0, 0);
    cyc("t8f3", F, 0, 0, 0);
    cyc("t8to", F, 0, 0, 1);
    cyc("t9f1", F, 0, 0, 0);
    cyc("t9f2", F, 0, 0, 0);
    trap = 1'b1;
    cyc("t9f3", F, 0, 0, 0);
    trap = 1'b0; fetch_ack = 1'b1;
    cyc("t9tr", F, 0, 1, 0);

    // Asynchronous reset in the middle of MEMORY.
    stage_enabled = 6'b010000;
    cyc("tad", D, 0, 0, 0);
    cyc("tae", E, 0, 0, 0);
    check_eq("ta_mreq_pre", 64'(mem_req), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ta_stage_async", 64'(stage_active), 64'(WB));
    check_eq("ta_mreq_async",  64'(mem_req), 64'd0);
    check_eq("ta_cnt_async",   64'(retire_count), 64'd0);
    check_eq("ta_pulses_async", 64'({instr_retired, trap_taken, bus_timeout}), 64'd0);
    @(posedge clk);
    #1;
    exp_cnt = 0;
    cyc("ta_rst", WB, 0, 0, 0);
    reset_n = 1'b1;
    cyc("ta_rel", WB, 0, 0, 0);
    cyc("ta_f", F, 0, 0, 0);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
